mat_mul_seq: RTL and testbench
==============================

MAT_MUL_SEQ -- requirements
Module: mat_mul_seq

Interface
REQ-001 SHALL have parameter DIM, default `MATRIX_DIM (8): matrix order; result count DIM*DIM.
REQ-002 SHALL have parameter AW, default 3: index width, log2(DIM).
REQ-003 SHALL have parameter TIMEOUT, default 16: max idle cycles in DRAIN between results.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to run one full product.
REQ-007 SHALL have port stall, input, 1: hold operand issue while high.
REQ-008 SHALL have port we_back, input, 1: valid strobe from the last adder-tree stage (we_out).
REQ-009 SHALL have port rd_en, output, 1: operand memory read strobe.
REQ-010 SHALL have port row_addr, output, AW: row index of A for current issue.
REQ-011 SHALL have port col_addr, output, AW: column index of B for current issue.
REQ-012 SHALL have port we_pipe, output, 1: valid into the multiplier stage (drives we_in chain).
REQ-013 SHALL have port res_we, output, 1: result memory write enable.
REQ-014 SHALL have port res_addr, output, 2*AW: result memory address, row-major.
REQ-015 SHALL have port busy, output, 1: high in ISSUE or DRAIN.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-017 SHALL have port err, output, 1: sticky error flag.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, DRAIN; all outputs registered.
REQ-019 IDLE: start=1 at edge N -> ISSUE, row/col counters and result counter cleared, err cleared; first rd_en visible in cycle after edge N.
REQ-020 start while busy SHALL be ignored, no effect on counters or err.
REQ-021 ISSUE, stall=0: rd_en=1, (row,col) advance col-first; col wraps DIM-1 -> 0 with row+1.
REQ-022 ISSUE, stall=1: rd_en=0, row/col hold; no pair skipped or repeated.
REQ-023 After issuing (DIM-1,DIM-1) SHALL enter DRAIN; rd_en=0 next cycle; exactly DIM*DIM issues per run.
REQ-024 we_pipe SHALL equal rd_en delayed one cycle (1-cycle operand read latency), in all states.
REQ-025 Each we_back=1 while busy: res_we=1 next cycle with res_addr = result count, count increments; res_addr = row*DIM+col by issue order.
REQ-026 DRAIN: on write of result DIM*DIM-1, done=1 same cycle as that res_we, return to IDLE.
REQ-027 we_back=1 in IDLE or after DIM*DIM results SHALL set err, no res_we.
REQ-028 we_back during ISSUE SHALL be accepted normally (issue and retire overlap).
REQ-029 res_addr SHALL hold last value when res_we=0.

Reset
REQ-030 rst=1 at any edge, including mid-run: state IDLE, rd_en, we_pipe, res_we, busy, done, err = 0; row_addr, col_addr, res_addr, counters = 0.
REQ-031 In-flight we_back after reset SHALL be treated per REQ-027 (flags err).

Configuration
REQ-032 Macro MAT_MUL_SEQ_TIMEOUT_EN SHALL compile in DRAIN watchdog.
REQ-033 Defined: counter clears on each we_back; TIMEOUT consecutive DRAIN cycles without we_back -> err=1, IDLE, no done.
REQ-034 Undefined: no watchdog; DRAIN waits indefinitely; err only per REQ-027.

Verification
REQ-035 DIM=8, start pulse, stall=0, we_back = we_pipe delayed 3 -> 64 rd_en cycles (0,0)..(7,7), res_addr 0..63, done once, err=0.
REQ-036 stall high on issue 10 for 5 cycles -> rd_en low 5 cycles, issue 10 = (1,2) once, 64 results total.
REQ-037 start pulses at cycles 5 and 20 of run -> ignored, sequence identical to REQ-035.
REQ-038 rst asserted at issue 30 -> all outputs 0 next cycle; trailing we_back pulses set err=1; new start clears err.
REQ-039 With MAT_MUL_SEQ_TIMEOUT_EN, TIMEOUT=16, withhold last 4 we_back -> err=1 after 16 DRAIN idle cycles, IDLE, no done.
REQ-040 Extra we_back after done -> err=1, res_we stays 0.

Source files
------------

// File: rtl/mat_mul_seq.sv
// mat_mul_seq: issue/retire controller for a DIM x DIM matrix product; MAT_MUL_SEQ_TIMEOUT_EN adds a DRAIN watchdog.
`ifndef MATRIX_DIM
`define MATRIX_DIM 8
`endif
module mat_mul_seq #(
  parameter int DIM = `MATRIX_DIM,
  parameter int AW = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          we_back,
  output logic          rd_en,
  output logic [AW-1:0] row_addr,
  output logic [AW-1:0] col_addr,
  output logic          we_pipe,
  output logic          res_we,
  output logic [2*AW-1:0] res_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int CW = 2*AW+1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] res_cnt;
  logic last_issue, col_wrap, full, accept, bad, fin, tmo;
  assign col_wrap = col_addr == AW'(DIM-1);
  assign last_issue = state == ISSUE && rd_en && col_wrap && row_addr == AW'(DIM-1);
  assign full = res_cnt == CW'(DIM*DIM);
  assign accept = we_back && state != IDLE && !full;
  assign bad = we_back && (state == IDLE || full);
  assign fin = accept && state == DRAIN && res_cnt == CW'(DIM*DIM-1);
`ifdef MAT_MUL_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT+1);
  logic [WW-1:0] wd;
  assign tmo = state == DRAIN && !we_back && wd == WW'(TIMEOUT-1);
  always_ff @(posedge clk) wd <= (rst || state != DRAIN || we_back) ? '0 : wd + WW'(1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE  ? (start ? ISSUE : IDLE) :
          state == ISSUE ? (last_issue ? DRAIN : ISSUE) :
          (fin || tmo)   ? IDLE : DRAIN;
  // rd_en marks the pair on row/col as issued this cycle; counters advance only after an issue
  always_ff @(posedge clk)
    if (rst) begin
      {rd_en, we_pipe, res_we, busy, done, err} <= '0;
      row_addr <= '0;
      col_addr <= '0;
      res_addr <= '0;
      res_cnt <= '0;
    end else begin
      we_pipe <= rd_en;
      res_we <= accept;
      done <= fin;
      busy <= nxt != IDLE;
      err <= bad || tmo || (err && !(state == IDLE && start));
      if (accept) begin
        res_addr <= res_cnt[2*AW-1:0];
        res_cnt <= res_cnt + CW'(1);
      end
      if (state == IDLE) begin
        rd_en <= start && !stall;
        if (start) begin
          row_addr <= '0;
          col_addr <= '0;
          res_cnt <= '0;
        end
      end else if (state == ISSUE) begin
        rd_en <= !stall && !last_issue;
        if (rd_en && !last_issue) begin
          col_addr <= col_wrap ? '0 : col_addr + AW'(1);
          if (col_wrap) row_addr <= row_addr + AW'(1);
        end
      end else rd_en <= 1'b0;
    end
endmodule

// File: tb/tb_mat_mul_seq.sv
// tb_mat_mul_seq: directed vector table plus full-product run sequences for mat_mul_seq (DIM=8).
module tb_mat_mul_seq;
  logic clk = 0, rst = 1, start = 0, stall = 0, we_back = 0;
  logic rd_en, we_pipe, res_we, busy, done, err;
  logic [2:0] row_addr, col_addr;
  logic [5:0] res_addr;
  logic [17:0] obs;
  int passed = 0, total = 0;
  typedef struct {
    logic r, s, st, wb;
    logic [17:0] exp;
  } vec_t;
  vec_t tv[14];

  mat_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .we_back(we_back),
    .rd_en(rd_en), .row_addr(row_addr), .col_addr(col_addr), .we_pipe(we_pipe),
    .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign obs = {rd_en, row_addr, col_addr, we_pipe, res_we, res_addr, busy, done, err};

  function automatic logic [17:0] e(int rd, int row, int col, int wp, int rw, int ra, int b, int d, int er);
    return {1'(rd), 3'(row), 3'(col), 1'(wp), 1'(rw), 6'(ra), 1'(b), 1'(d), 1'(er)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step(input logic s, input logic st, input logic wb);
    start = s;
    stall = st;
    we_back = wb;
    @(posedge clk);
    #1;
  endtask

  // we_back is fed back from we_pipe three cycles later; hold withholds the last results
  task automatic run(input int stall_at, input int stall_len, input bit starts, input int rst_at,
                     input int hold, input int budget, output int issues, output int results,
                     output int dones, output int low, output int lag, output int idle);
    logic [3:0] sh = '0;
    logic prev_rd = 1'b0, st, wb, r;
    int stalled = 0, fed = 0;
    bit did = 0;
    issues = 0; results = 0; dones = 0; low = 0; lag = 0; idle = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (we_pipe !== prev_rd) lag++;
      prev_rd = rd_en;
      if (rd_en) begin
        chk("issue_order", {row_addr, col_addr}, issues);
        issues++;
      end else if (busy && issues < 64) low++;
      if (res_we) begin
        chk("res_addr", res_addr, results);
        results++;
        idle = 0;
      end else if (busy) idle++;
      if (done) begin
        dones++;
        chk("done_with_last", {31'd0, res_we && results == 64}, 1);
      end
      if (cyc > 0 && !busy && sh == 0) break;
      sh = {sh[2:0], we_pipe};
      st = issues == stall_at && stalled < stall_len;
      if (st) stalled++;
      wb = sh[3] && fed < 64 - hold;
      if (wb) fed++;
      r = rst_at >= 0 && issues == rst_at && !did;
      rst = r;
      step(starts && (cyc == 5 || cyc == 20), st, wb);
      rst = 0;
      if (r) begin
        chk("rst_mid_outputs", obs, 0);
        prev_rd = 1'b0;
        did = 1;
      end
    end
  endtask

  initial begin
    int is, rs, dn, lo, lg, id;
    tv[0]  = '{0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tv[1]  = '{0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 1, 0, 0)};
    tv[2]  = '{0, 0, 0, 0, e(1, 0, 1, 1, 0, 0, 1, 0, 0)};
    tv[3]  = '{0, 1, 1, 0, e(0, 0, 2, 1, 0, 0, 1, 0, 0)};
    tv[4]  = '{0, 0, 1, 0, e(0, 0, 2, 0, 0, 0, 1, 0, 0)};
    tv[5]  = '{0, 0, 0, 0, e(1, 0, 2, 0, 0, 0, 1, 0, 0)};
    tv[6]  = '{0, 0, 0, 1, e(1, 0, 3, 1, 1, 0, 1, 0, 0)};
    tv[7]  = '{0, 0, 0, 0, e(1, 0, 4, 1, 0, 0, 1, 0, 0)};
    tv[8]  = '{0, 0, 0, 1, e(1, 0, 5, 1, 1, 1, 1, 0, 0)};
    tv[9]  = '{1, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tv[10] = '{0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tv[11] = '{0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tv[12] = '{0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 1, 0, 0)};
    tv[13] = '{1, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset_state", obs, 0);
    rst = 0;
    foreach (tv[i]) begin
      rst = tv[i].r;
      step(tv[i].s, tv[i].st, tv[i].wb);
      chk($sformatf("vec%0d", i), obs, tv[i].exp);
    end
    rst = 0;
    run(-1, 0, 0, -1, 0, 300, is, rs, dn, lo, lg, id);
    chk("plain_issues", is, 64);
    chk("plain_results", rs, 64);
    chk("plain_dones", dn, 1);
    chk("plain_err", err, 0);
    chk("plain_we_pipe_lag", lg, 0);
    chk("plain_no_gap", lo, 0);
    step(0, 0, 1);
    chk("extra_wb_no_write", res_we, 0);
    chk("extra_wb_err", err, 1);
    step(0, 0, 0);
    chk("err_sticky", err, 1);
    run(10, 5, 0, -1, 0, 300, is, rs, dn, lo, lg, id);
    chk("stall_issues", is, 64);
    chk("stall_results", rs, 64);
    chk("stall_gap", lo, 5);
    chk("stall_dones", dn, 1);
    chk("stall_err_cleared", err, 0);
    chk("stall_we_pipe_lag", lg, 0);
    run(-1, 0, 1, -1, 0, 300, is, rs, dn, lo, lg, id);
    chk("restart_issues", is, 64);
    chk("restart_results", rs, 64);
    chk("restart_dones", dn, 1);
    chk("restart_err", err, 0);
    chk("restart_no_gap", lo, 0);
    run(-1, 0, 0, 30, 0, 300, is, rs, dn, lo, lg, id);
    chk("rst_issues_stop", is, 30);
    chk("rst_trailing_err", err, 1);
    chk("rst_we_pipe_lag", lg, 0);
    step(1, 0, 0);
    chk("new_start_clears_err", err, 0);
    rst = 1;
    step(0, 0, 0);
    rst = 0;
`ifdef MAT_MUL_SEQ_TIMEOUT_EN
    run(-1, 0, 0, -1, 4, 300, is, rs, dn, lo, lg, id);
    chk("wd_results", rs, 60);
    chk("wd_idle_cycles", id, 15);
    chk("wd_err", err, 1);
    chk("wd_idle", busy, 0);
    chk("wd_no_done", dn, 0);
`else
    run(-1, 0, 0, -1, 4, 150, is, rs, dn, lo, lg, id);
    chk("drain_results", rs, 60);
    chk("drain_waits", busy, 1);
    chk("drain_no_err", err, 0);
    chk("drain_no_done", dn, 0);
`endif
    rst = 1;
    step(0, 0, 0);
    rst = 0;
    chk("final_reset", obs, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
